program_counter: RTL and testbench



---
 rtl/program_counter.sv | 53 +++++
 tb/tb_program_counter.sv | 104 ++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Program counter register for the single-cycle MIPS datapath; loads next-PC every cycle.
// Optional alignment check enabled by defining PC_ALIGN_CHECK_EN (adds the misaligned port).
module program_counter #(
  parameter int unsigned          WIDTH      = 32,
  parameter logic [WIDTH-1:0]     RESET_ADDR = '0
) (
  input  logic [WIDTH-1:0] addr_in,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] addr_out
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             misaligned
`endif
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_next_pc;

`ifdef PC_ALIGN_CHECK_EN
  logic r_misaligned;

  // Low bits are forced to zero so the fetch address is always word-aligned.
  always_comb begin
    w_next_pc = {addr_in[WIDTH-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= |addr_in[1:0];
    end
  end

  assign misaligned = r_misaligned;
`else
  always_comb begin
    w_next_pc = addr_in;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_ADDR;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign addr_out = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter: reset, sequential fetch, jump, wrap,
// mid-run reset, and (when PC_ALIGN_CHECK_EN is defined) the misaligned flag.
module tb_program_counter;

  logic        clk;
  logic        rst;
  logic [31:0] addr_in;
  logic [31:0] addr_out;
`ifdef PC_ALIGN_CHECK_EN
  logic        misaligned;
`endif

  int unsigned n_checks;
  int unsigned n_pass;

  program_counter #(
    .WIDTH      (32),
    .RESET_ADDR (32'h0000_0000)
  ) dut (
    .addr_in  (addr_in),
    .clk      (clk),
    .rst      (rst),
    .addr_out (addr_out)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misaligned (misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Apply inputs, take one rising edge, then check addr_out just after it.
  task automatic tick(input string tag, input logic r, input logic [31:0] a, input logic [31:0] exp);
    rst     = r;
    addr_in = a;
    @(posedge clk);
    #1;
    check(tag, addr_out, exp);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    addr_in  = 32'h1234_5678;
    @(negedge clk);

    tick("reset_edge1", 1'b1, 32'h1234_5678, 32'h0000_0000);
    tick("reset_edge2", 1'b1, 32'h1234_5678, 32'h0000_0000);
    tick("reset_x_in", 1'b1, 32'hxxxx_xxxx, 32'h0000_0000);
`ifdef PC_ALIGN_CHECK_EN
    check("reset_misaligned", {31'd0, misaligned}, 32'd0);
`endif

    for (int i = 1; i <= 24; i++) begin
      tick("seq_fetch", 1'b0, 32'(i * 4), 32'(i * 4));
    end
    check("seq_final", addr_out, 32'd96);

    tick("reset_again", 1'b1, 32'hDEAD_BEEC, 32'h0000_0000);
    tick("inc_4", 1'b0, 32'h0000_0004, 32'h0000_0004);
    tick("inc_8", 1'b0, 32'h0000_0008, 32'h0000_0008);
    tick("jump", 1'b0, 32'h0040_0000, 32'h0040_0000);
    tick("jump_inc1", 1'b0, 32'h0040_0004, 32'h0040_0004);
    tick("jump_inc2", 1'b0, 32'h0040_0008, 32'h0040_0008);

    tick("wrap_top", 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    tick("wrap_zero", 1'b0, 32'h0000_0000, 32'h0000_0000);
    tick("wrap_next", 1'b0, 32'h0000_0004, 32'h0000_0004);

    tick("pre_midreset", 1'b0, 32'h0000_0040, 32'h0000_0040);
    tick("midreset", 1'b1, 32'h0000_0999, 32'h0000_0000);
    tick("post_midreset", 1'b0, 32'h0000_0044, 32'h0000_0044);

`ifdef PC_ALIGN_CHECK_EN
    tick("align_106", 1'b0, 32'h0000_0106, 32'h0000_0104);
    check("misaligned_set", {31'd0, misaligned}, 32'd1);
    tick("align_108", 1'b0, 32'h0000_0108, 32'h0000_0108);
    check("misaligned_clr", {31'd0, misaligned}, 32'd0);
    tick("align_103", 1'b0, 32'h0000_0103, 32'h0000_0100);
    check("misaligned_set2", {31'd0, misaligned}, 32'd1);
    tick("align_rst", 1'b1, 32'h0000_0107, 32'h0000_0000);
    check("misaligned_rst", {31'd0, misaligned}, 32'd0);
`else
    tick("verbatim_106", 1'b0, 32'h0000_0106, 32'h0000_0106);
    tick("verbatim_103", 1'b0, 32'h0000_0103, 32'h0000_0103);
    tick("verbatim_a5", 1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
